mod_exp_engine: RTL and testbench

//   Parametrised modular exponentiation engine: result = base^exp mod modulus, right-to-left binary method.

---
 rtl/mod_exp_pkg.sv | 19 +
 rtl/mod_mul_serial.sv | 73 +++++++
 rtl/mod_exp_engine.sv | 145 ++++++++++++++
 tb/tb_mod_exp_engine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine: FSM encoding and width helpers.
package mod_exp_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_REDUCE = 3'd2;
  localparam logic [2:0] ST_LOOP   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // Counter must hold NBITS (multiplier step count) for any operand width.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 2);
  endfunction

  function automatic int mul_lat(input int nbits);
    return nbits + 1;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Serial modular multiplier p = x*y mod n (x,y < n), MSB-first interleaved, NBITS+1 cycles go-to-rdy.
module mod_mul_serial
  import mod_exp_pkg::*;
#(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [NBITS-1:0] x,
  input  logic [NBITS-1:0] y,
  input  logic [NBITS-1:0] n,
  output logic             rdy,
  output logic [NBITS-1:0] p
);

  localparam int CNT_W = cnt_width(NBITS);

  logic [NBITS-1:0] r_x;
  logic [NBITS-1:0] r_y;
  logic [NBITS-1:0] r_n;
  logic [NBITS-1:0] r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_rdy;

  logic [NBITS+1:0] w_n_ext;
  logic [NBITS+1:0] w_t0;
  logic [NBITS+1:0] w_t1;
  logic [NBITS+1:0] w_t2;

  // r < n, so 2r + x < 3n: two conditional subtractions bring it back below n.
  always_comb begin
    w_n_ext = {2'b00, r_n};
    w_t0    = {1'b0, r_r, 1'b0} + (r_y[NBITS-1] ? {2'b00, r_x} : '0);
    w_t1    = (w_t0 >= w_n_ext) ? (w_t0 - w_n_ext) : w_t0;
    w_t2    = (w_t1 >= w_n_ext) ? (w_t1 - w_n_ext) : w_t1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_n   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (go) begin
        r_x   <= x;
        r_y   <= y;
        r_n   <= n;
        r_r   <= '0;
        r_cnt <= CNT_W'(NBITS);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_r   <= w_t2[NBITS-1:0];
        r_y   <= r_y << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_run <= 1'b0;
          r_rdy <= 1'b1;
        end
      end
    end
  end

  assign rdy = r_rdy;
  assign p   = r_r;

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation base^exp mod modulus, right-to-left binary method with two serial multipliers.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int NBITS    = 256,
  parameter int EXP_BITS = NBITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NBITS-1:0]    base,
  input  logic [EXP_BITS-1:0] exp,
  input  logic [NBITS-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NBITS-1:0]    result,
  output logic [2:0]          dbg_state
);

  // Handshake: start is taken only while busy=0 and operands are captured in that cycle;
  // busy stays high from the next cycle through the single done cycle, where result/err are valid.

  localparam int CNT_W = cnt_width(NBITS);

  logic [2:0]          r_state;
  logic [NBITS-1:0]    r_a;
  logic [NBITS-1:0]    r_n;
  logic [EXP_BITS-1:0] r_er;
  logic [NBITS-1:0]    r_x;
  logic [NBITS-1:0]    r_acc;
  logic [NBITS-1:0]    r_red;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wait;
  logic                r_err;
  logic [NBITS-1:0]    r_result;

  logic [NBITS:0]      w_red_shift;
  logic [NBITS:0]      w_red_sub;
  logic [NBITS-1:0]    w_red_next;
  logic                w_go;
  logic                w_sq_rdy;
  logic                w_pr_rdy;
  logic                w_rdy;
  logic [NBITS-1:0]    w_sq;
  logic [NBITS-1:0]    w_pr;

  always_comb begin
    w_red_shift = {r_red, r_a[NBITS-1]};
    w_red_sub   = w_red_shift - {1'b0, r_n};
    w_red_next  = (w_red_shift >= {1'b0, r_n}) ? w_red_sub[NBITS-1:0] : w_red_shift[NBITS-1:0];
  end

  assign w_go  = (r_state == ST_LOOP) && !r_wait && (r_er != '0);
  assign w_rdy = w_sq_rdy & w_pr_rdy;

  mod_mul_serial #(.NBITS(NBITS)) u_square (
    .clk (clk), .rst (rst), .go (w_go),
    .x   (r_x), .y   (r_x), .n  (r_n),
    .rdy (w_sq_rdy), .p (w_sq)
  );

  mod_mul_serial #(.NBITS(NBITS)) u_multiply (
    .clk (clk), .rst (rst), .go (w_go),
    .x   (r_acc), .y (r_x), .n  (r_n),
    .rdy (w_pr_rdy), .p (w_pr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_n      <= '0;
      r_er     <= '0;
      r_x      <= '0;
      r_acc    <= '0;
      r_red    <= '0;
      r_cnt    <= '0;
      r_wait   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= base;
            r_er    <= exp;
            r_n     <= modulus;
            r_err   <= 1'b0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // The error path reuses the loop's exit cycle, so it finishes through the same sequence.
          if (r_n < NBITS'(2)) begin
            r_err   <= 1'b1;
            r_er    <= '0;
            r_wait  <= 1'b0;
            r_state <= ST_LOOP;
          end else begin
            r_acc   <= NBITS'(1);
            r_red   <= '0;
            r_cnt   <= CNT_W'(NBITS - 1);
            r_state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          r_red <= w_red_next;
          r_a   <= r_a << 1;
          if (r_cnt == '0) begin
            r_x     <= w_red_next;
            r_wait  <= 1'b0;
            r_state <= ST_LOOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_LOOP: begin
          if (r_wait) begin
            if (w_rdy) begin
              r_wait <= 1'b0;
              r_x    <= w_sq;
              if (r_er[0]) r_acc <= w_pr;
              r_er   <= r_er >> 1;
            end
          end else if (r_er == '0) begin
            r_result <= r_err ? '0 : r_acc;
            r_state  <= ST_FINISH;
          end else begin
            r_wait <= 1'b1;
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign err       = r_err;
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at NBITS=16: results, exact latency, error path, ignored start, reset.
module tb_mod_exp_engine;

  localparam int NB = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NB-1:0] base;
  logic [NB-1:0] e_in;
  logic [NB-1:0] modulus;
  logic          busy;
  logic          done;
  logic          err;
  logic [NB-1:0] result;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc;
  int done_seen;

  mod_exp_engine #(.NBITS(NB), .EXP_BITS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .exp       (e_in),
    .modulus   (modulus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drives a one-cycle start; returns at the negedge of the cycle after the start cycle (cycle 1).
  task automatic launch(input logic [NB-1:0] a, input logic [NB-1:0] e, input logic [NB-1:0] n);
    @(negedge clk);
    start   = 1'b1;
    base    = a;
    e_in    = e;
    modulus = n;
    @(negedge clk);
    start   = 1'b0;
    base    = NB'($urandom_range(0, 65535));
    e_in    = NB'($urandom_range(0, 65535));
    modulus = NB'($urandom_range(0, 65535));
  endtask

  // Waits (bounded) for done starting from cycle index c0, then checks latency, outputs and pulse width.
  task automatic wait_done(input string tag, input int c0, input logic [NB-1:0] exp_res,
                           input logic exp_err, input int exp_lat);
    cyc = c0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    base    = '0;
    e_in    = '0;
    modulus = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;

    // 4^13 mod 497 = 445, L=4: 2+16+4*18+1 = 91
    launch(16'd4, 16'd13, 16'd497);
    wait_done("basic", 1, 16'd445, 1'b0, 91);

    // base >= modulus: 500 mod 497 = 3, 3^5 = 243, L=3 -> 73
    launch(16'd500, 16'd5, 16'd497);
    wait_done("reduce", 1, 16'd243, 1'b0, 73);

    // e=0 -> 1 after 19 cycles
    launch(16'd7, 16'd0, 16'd11);
    wait_done("exp_zero", 1, 16'd1, 1'b0, 19);

    // n<2 -> err in 3 cycles
    launch(16'd9, 16'd77, 16'd1);
    wait_done("n_one", 1, 16'd0, 1'b1, 3);
    launch(16'd5, 16'd3, 16'd0);
    wait_done("n_zero", 1, 16'd0, 1'b1, 3);

    // next valid op clears err: 3^7 = 2187 mod 100 = 87, L=3 -> 73
    launch(16'd3, 16'd7, 16'd100);
    wait_done("err_clear", 1, 16'd87, 1'b0, 73);

    // smallest legal modulus: 3 mod 2 = 1 -> 1, L=3 -> 73
    launch(16'd3, 16'd5, 16'd2);
    wait_done("n_two", 1, 16'd1, 1'b0, 73);

    // full width: (-1)^odd mod 65535 = 65534, L=16 -> 2+16+16*18+1 = 307
    launch(16'd65534, 16'd65535, 16'd65535);
    wait_done("full_width", 1, 16'd65534, 1'b0, 307);

    // second start mid-LOOP must be ignored
    launch(16'd4, 16'd13, 16'd497);
    repeat (40) @(negedge clk);
    check("mid_state_loop", 32'(dbg_state), 32'd3);
    start   = 1'b1;
    base    = 16'd2;
    e_in    = 16'd3;
    modulus = 16'd5;
    @(negedge clk);
    start   = 1'b0;
    wait_done("ignored_start", 42, 16'd445, 1'b0, 91);

    // reset mid-LOOP: outputs drop, no done afterwards
    launch(16'd4, 16'd13, 16'd497);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);

    // after reset: 2^10 = 1024 mod 1000 = 24, L=4 -> 91
    launch(16'd2, 16'd10, 16'd1000);
    wait_done("after_rst", 1, 16'd24, 1'b0, 91);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
